// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with a pending-write scoreboard,
// a selectable hardwired-zero register and a sequenced clear engine.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ra  / rd         NUM_RD packed read addresses / read data (combinational)
//   rd_pend          per read port: addressed register has an outstanding write
//   we, wa, wd       write-back port (takes effect on the rising edge)
//   iss_v, iss_addr  issue port: mark iss_addr as pending
//   clr_req          single-cycle request to clear the whole array
//   ready            1 = array usable, 0 = clear in progress
//
// Optional feature: define REGFILE_BYPASS_EN for same-cycle
// write-to-read forwarding on every read port.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     clr_req,
    output logic                     ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     cnt_d;
    logic [DEPTH-1:0]    pend_q;
    logic [DEPTH-1:0]    pend_d;
    logic                ready_q;
    logic                ready_d;

    // Storage has no reset; the clear engine zeroes it after reset.
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic                wr_ok;
    logic                iss_ok;

    assign wr_ok  = we && (wa != ZERO_A);
    assign iss_ok = iss_v && (iss_addr != ZERO_A);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        mem_we  = 1'b0;
        mem_wa  = wa;
        mem_wd  = wd;
        unique case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q[ADDR_W-1:0];
                mem_wd = '0;
                pend_d = '0;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (clr_req) begin
                    // Clear wins; same-cycle write and issue are dropped.
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    pend_d  = '0;
                end else begin
                    if (wr_ok) begin
                        mem_we     = 1'b1;
                        pend_d[wa] = 1'b0;
                    end
                    // Applied after the write so a new producer wins.
                    if (iss_ok) begin
                        pend_d[iss_addr] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
                pend_d  = '0;
            end
        endcase
        ready_d = (state_d == S_READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            pend_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    logic [ADDR_W-1:0] rd_addr;

    always_comb begin
        rd      = '0;
        rd_pend = '0;
        rd_addr = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr = ra[k*ADDR_W +: ADDR_W];
            if (state_q == S_READY && rd_addr != ZERO_A) begin
                rd[k*DATA_W +: DATA_W] = mem[rd_addr];
                rd_pend[k]             = pend_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
                if (we && wa == rd_addr) begin
                    rd[k*DATA_W +: DATA_W] = wd;
                    rd_pend[k]             = 1'b0;
                end
`else
`endif
            end
        end
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed plus random checks of reg_file_mp
// against an array/queue-level reference model.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_pend;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_v;
    logic [4:0]  iss_addr;
    logic        clr_req;
    logic        ready;

    reg_file_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rd       (rd),
        .rd_pend  (rd_pend),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_v    (iss_v),
        .iss_addr (iss_addr),
        .clr_req  (clr_req),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    logic [31:0] m_mem [32];
    bit          m_pend [32];
    int          m_busy;
    int          n_pass;
    int          n_total;
    int          lowc;

    task automatic m_reset();
        m_busy = 32;
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic m_update();
        if (!rst_n) begin
            m_reset();
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (clr_req) begin
            m_reset();
        end else begin
            if (we && wa != 5'd31) begin
                m_mem[wa]  = wd;
                m_pend[wa] = 1'b0;
            end
            if (iss_v && iss_addr != 5'd31) begin
                m_pend[iss_addr] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input int k);
        logic [4:0] a;
        a = ra[k*5 +: 5];
        if (m_busy > 0 || a == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_pend(input int k);
        logic [4:0] a;
        a = ra[k*5 +: 5];
        if (m_busy > 0 || a == 5'd31) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        chk("ready", {63'd0, ready}, {63'd0, m_busy == 0});
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd%0d", k), {32'd0, rd[k*32 +: 32]},
                {32'd0, exp_rd(k)});
            chk($sformatf("pend%0d", k), {63'd0, rd_pend[k]},
                {63'd0, exp_pend(k)});
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        if (!rst_n) m_reset();
        #1;
        check_outputs();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic idle();
        we      = 1'b0;
        iss_v   = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        idle();
        ra       = '0;
        wa       = '0;
        wd       = '0;
        iss_addr = '0;
        m_reset();
        @(negedge clk);

        // Reset, then clear sequence of exactly 32 cycles
        repeat (3) step();
        rst_n = 1'b1;
        wait_ready(lowc);
        chk("clear_len", 64'(lowc), 64'd32);
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a)};
            #1 chk("init_zero", rd, 64'd0);
            step();
        end

        // Basic write/read
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step();
        idle(); ra[4:0] = 5'd5;
        #1 chk("wr5", {32'd0, rd[31:0]}, 64'hDEADBEEF);
        step();

        // Zero register ignores writes
        we = 1'b1; wa = 5'd31; wd = 32'h12345678;
        step();
        idle(); ra[4:0] = 5'd31;
        #1 chk("zero_reg", {32'd0, rd[31:0]}, 64'd0);
        step();

        // Scoreboard
        iss_v = 1'b1; iss_addr = 5'd7;
        step();
        idle(); ra[4:0] = 5'd7;
        #1 chk("iss7_pend", {63'd0, rd_pend[0]}, 64'd1);
        step();
        we = 1'b1; wa = 5'd7; wd = 32'h1;
        step();
        idle();
        #1 chk("wb7_pend", {63'd0, rd_pend[0]}, 64'd0);
        chk("wb7_data", {32'd0, rd[31:0]}, 64'd1);
        step();
        we = 1'b1; wa = 5'd7; wd = 32'hCAFEF00D;
        iss_v = 1'b1; iss_addr = 5'd7;
        step();
        idle();
        #1 chk("both7_pend", {63'd0, rd_pend[0]}, 64'd1);
        chk("both7_data", {32'd0, rd[31:0]}, 64'hCAFEF00D);
        step();

        // Forwarding behaviour
        we = 1'b1; wa = 5'd3; wd = 32'h11111111;
        step();
        wd = 32'hA5A5A5A5; ra[9:5] = 5'd3;
`ifdef REGFILE_BYPASS_EN
        #1 chk("byp_same", {32'd0, rd[63:32]}, 64'hA5A5A5A5);
`else
        #1 chk("byp_same", {32'd0, rd[63:32]}, 64'h11111111);
`endif
        step();
        idle();
        #1 chk("byp_next", {32'd0, rd[63:32]}, 64'hA5A5A5A5);
        step();

        // Random traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            we       = 1'($urandom_range(0, 1));
            wa       = 5'($urandom_range(0, 31));
            wd       = $urandom;
            iss_v    = 1'($urandom_range(0, 1));
            iss_addr = ($urandom_range(0, 3) == 0) ? wa
                                                   : 5'($urandom_range(0, 31));
            ra       = 10'($urandom);
            clr_req  = ($urandom_range(0, 59) == 0);
            step();
        end
        idle();
        wait_ready(lowc);
        chk("drain_ready", {63'd0, ready}, 64'd1);

        // Fill, then clear with a colliding write to reg 2
        for (int a = 0; a < 31; a++) begin
            we = 1'b1; wa = 5'(a); wd = 32'(a) * 32'h01010101 + 32'h1;
            step();
        end
        we = 1'b1; wa = 5'd2; wd = 32'hFFFFFFFF; clr_req = 1'b1;
        step();
        idle();
        wait_ready(lowc);
        chk("clr_len", 64'(lowc), 64'd32);
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a)};
            #1 chk("clr_zero", rd, 64'd0);
            step();
        end

        // Reset in the middle of a clear restarts the count
        clr_req = 1'b1;
        step();
        idle();
        repeat (10) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        wait_ready(lowc);
        chk("rst_mid_len", 64'(lowc), 64'd32);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
